// File: rtl/text_entry_ctrl.sv
// text_entry_ctrl: keyboard text-entry sequencer for the POV display.
// Builds a message buffer from ASCII keystrokes. It handles delete, composes
// tilde+n into a single stored code, takes a two-digit numeric parameter after
// the first Enter, and commits both on the second Enter.
//
// state | meaning
// ------+---------------------------------------------------------------
// TEXT  | collecting printable characters into the message buffer
// NUM   | collecting up to two decimal digits of the rotation parameter
module text_entry_ctrl #(
    parameter int         MAX_LEN  = 16,
    parameter logic [6:0] ENE_CODE = 7'h7F,
    parameter int         NUM_MAX  = 99
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [6:0]                 char,
    input  logic                       char_valid,
    input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
    output logic [6:0]                 rd_data,
    output logic [$clog2(MAX_LEN):0]   msg_len,
    output logic [6:0]                 num_val,
    output logic                       mode,
    output logic                       tilde_pend,
    output logic                       msg_done,
    output logic                       err
);

    localparam int AW = $clog2(MAX_LEN);
    localparam logic [AW:0] LEN_FULL = (AW+1)'(MAX_LEN);
    localparam logic [10:0] NUM_SAT  = 11'(NUM_MAX);

    localparam logic [6:0] K_ENTER = 7'h04;
    localparam logic [6:0] K_DEL   = 7'h08;
    localparam logic [6:0] K_TILDE = 7'h7E;

    typedef enum logic {
        TEXT = 1'b0,
        NUM  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [6:0]  buf_mem [MAX_LEN];
    logic [1:0]  dcnt, dcnt_nxt;
    // Set by a commit: the next stored key starts a fresh message while the
    // old one stays readable until then.
    logic        committed, committed_nxt;

    logic [AW:0] len_nxt, eff_len;
    logic [6:0]  num_nxt;
    logic        tilde_nxt, done_nxt, err_nxt;
    logic        do_store, pass;
    logic [6:0]  store_code;
    logic        wr_en;
    logic [AW-1:0] wr_addr;
    logic [10:0] num_calc;
    logic [6:0]  num_sat;

    logic is_enter, is_del, is_tilde, is_n, is_digit, is_print;

    assign is_enter = (char == K_ENTER);
    assign is_del   = (char == K_DEL);
    assign is_tilde = (char == K_TILDE);
    assign is_n     = (char == 7'h6E) || (char == 7'h4E);
    assign is_digit = (char >= 7'h30) && (char <= 7'h39);
    assign is_print = (char >= 7'h20) && (char <= 7'h7D);

    assign rd_data = buf_mem[rd_addr];
    assign mode    = (state == NUM);

    // Next digit value: widened product plus the low nibble of the digit, then saturated.
    always_comb begin
        num_calc = ({4'b0, num_val} * 11'd10) + {7'b0, char[3:0]};
        num_sat  = (num_calc > NUM_SAT) ? NUM_SAT[6:0] : num_calc[6:0];
    end

    // Next-state and register update decisions for one keystroke.
    always_comb begin
        state_nxt     = state;
        len_nxt       = msg_len;
        num_nxt       = num_val;
        dcnt_nxt      = dcnt;
        tilde_nxt     = tilde_pend;
        committed_nxt = committed;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        do_store      = 1'b0;
        pass          = 1'b1;
        store_code    = char;
        wr_en         = 1'b0;
        wr_addr       = '0;
        eff_len       = committed ? '0 : msg_len;

        if (char_valid) begin
            unique case (state)
                TEXT: begin
                    if (tilde_pend) begin
                        if (is_n) begin
                            tilde_nxt  = 1'b0;
                            do_store   = 1'b1;
                            store_code = ENE_CODE;
                            pass       = 1'b0;
                        end else if (is_del) begin
                            tilde_nxt = 1'b0;
                            pass      = 1'b0;
                        end else if (is_tilde) begin
                            pass = 1'b0;
                        end else if (is_enter || is_print) begin
                            tilde_nxt = 1'b0;
                        end
                    end

                    if (pass) begin
                        if (is_tilde) begin
                            tilde_nxt = 1'b1;
                            if (committed) begin
                                len_nxt       = '0;
                                committed_nxt = 1'b0;
                            end
                        end else if (is_print) begin
                            do_store = 1'b1;
                        end else if (is_del) begin
                            if (msg_len != '0) begin
                                len_nxt       = msg_len - (AW+1)'(1);
                                committed_nxt = 1'b0;
                            end else begin
                                err_nxt = 1'b1;
                            end
                        end else if (is_enter) begin
                            if (msg_len != '0) begin
                                state_nxt     = NUM;
                                num_nxt       = '0;
                                dcnt_nxt      = '0;
                                tilde_nxt     = 1'b0;
                                committed_nxt = 1'b0;
                            end else begin
                                err_nxt = 1'b1;
                            end
                        end
                    end

                    if (do_store) begin
                        if (eff_len < LEN_FULL) begin
                            wr_en         = 1'b1;
                            wr_addr       = eff_len[AW-1:0];
                            len_nxt       = eff_len + (AW+1)'(1);
                            committed_nxt = 1'b0;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end

                NUM: begin
                    if (is_digit) begin
                        if (dcnt == 2'd2) begin
                            err_nxt = 1'b1;
                        end else begin
                            num_nxt  = num_sat;
                            dcnt_nxt = dcnt + 2'd1;
                        end
                    end else if (is_del) begin
                        num_nxt  = '0;
                        dcnt_nxt = '0;
                    end else if (is_enter) begin
                        done_nxt      = 1'b1;
                        state_nxt     = TEXT;
                        committed_nxt = 1'b1;
                    end else if (is_print) begin
                        err_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    // State and control registers; reset wins over a concurrent keystroke.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TEXT;
            msg_len    <= '0;
            num_val    <= '0;
            dcnt       <= '0;
            tilde_pend <= 1'b0;
            committed  <= 1'b0;
            msg_done   <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            msg_len    <= len_nxt;
            num_val    <= num_nxt;
            dcnt       <= dcnt_nxt;
            tilde_pend <= tilde_nxt;
            committed  <= committed_nxt;
            msg_done   <= done_nxt;
            err        <= err_nxt;
        end
    end

    // Message storage; contents are not reset, only the length is.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            buf_mem[wr_addr] <= store_code;
        end
    end

endmodule
